prbs9_checker: RTL and testbench
================================

Name: prbs9_checker

Overview:
- Receive-side counterpart of the PRBS9 generator (polynomial x^9 + x^5 + 1).
- Sees the same bit stream the generator emits, one bit per enabled clock.
- Self-synchronises to the incoming stream, then runs its own local LFSR and counts bit errors against it.
- Sits at the receive end of the loopback/BER test path; lock and error status are registered outputs for status logic.

Parameters:
- LOCK_COUNT, 16: consecutive correct predictions in SEARCH required to declare lock.
- WINDOW, 64: enabled-bit window length used in LOCKED for loss-of-lock evaluation.
- UNLOCK_ERRS, 8: errors within one WINDOW that force a return to SEARCH.
- CNT_W, 16: width of the error and bit counters.

Ports:
- clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_bit  input  1  received PRBS bit, sampled only when i_enable=1.
- i_enable  input  1  sample strobe; one received bit per clock with i_enable=1.
- i_clear  input  1  synchronous clear of o_err_count and o_bit_count only.
- o_locked  output  1  1 while in LOCKED.
- o_error  output  1  one-cycle pulse: the bit sampled on the previous edge mismatched in LOCKED.
- o_err_count  output  CNT_W  saturating count of errored bits while LOCKED.
- o_bit_count  output  CNT_W  saturating count of bits checked while LOCKED.

Behaviour:
- Reset (async, immediate) values:
  - state = SEARCH; history h[8:0] = 0; fill = 0; match_cnt = 0; window counters = 0.
  - All outputs 0.
- Recurrence: for stream b[n], b[n] = b[n-9] ^ b[n-5].
  - h[8] holds the oldest bit.
  - Prediction p = h[8] ^ h[4].
  - Shift rule: h <= {h[7:0], x}.
- i_enable=0: all state, counters and history hold; o_error = 0.
- SEARCH, on each enabled edge:
  - x = i_bit.
  - fill increments until it saturates at 9.
  - Once fill = 9 (prior to this edge):
    - i_bit == p and h != 0: match_cnt increments.
    - Otherwise match_cnt clears. The all-zero history never counts as a match, which blocks lock onto a stuck-at-0 line.
  - If match_cnt reaches LOCK_COUNT on this edge, the next state is LOCKED and o_locked rises on this same edge.
  - Counters do not advance in SEARCH.
- LOCKED, on each enabled edge:
  - x = p (free-running local LFSR; received bits do not enter h).
  - o_bit_count increments, saturating at all-ones.
  - Mismatch (i_bit != p):
    - o_error = 1 for exactly one cycle.
    - o_err_count increments, saturating.
    - The window error count increments.
  - Window bookkeeping:
    - The window bit counter wraps after WINDOW bits.
    - At wrap, the window error count clears.
  - If the window error count reaches UNLOCK_ERRS, the next state is SEARCH on that edge:
    - o_locked falls on that edge.
    - fill, match_cnt and the window counters clear.
    - h is kept but ignored, because fill = 0 forces a 9-bit refill.
- Lock latency: from reset or unlock, o_locked rises on the edge sampling enabled bit 9+LOCK_COUNT (default 25). This requires the stream to be error-free and nonzero.
- i_clear:
  - Synchronous; takes priority over an increment on the same edge (result is 0).
  - Does not affect state, h or the window counters.
- Async reset mid-LOCKED: immediate return to reset values. Relock takes the full 9+LOCK_COUNT bits.

Test Plan:
- Generator stream, seed 0x1AA, i_enable=1 continuously -> o_locked=1 after 25th sampled bit; afterwards o_error=0. After 100 further bits: o_bit_count=100, o_err_count=0.
- Locked, invert one bit -> o_error high exactly one cycle after that sample; o_err_count=1; o_locked stays 1; the local LFSR is unaffected, so the next bits show no errors.
- Locked, invert 8 bits within one 64-bit window -> o_locked falls on the edge sampling the 8th error. Clean stream afterwards -> relock after 25 more bits.
- Constant i_bit=0 for 200 bits after reset -> o_locked stays 0, counters stay 0.
- Toggle i_enable (1 of every 3 cycles) with the stream held between strobes -> lock after 25 strobes, zero errors. With i_enable=0, counters and o_locked hold.
- Assert i_reset mid-LOCKED with o_err_count=3 -> all outputs 0 immediately. Then a separate run: pulse i_clear while an error lands on the same edge -> o_err_count=0, o_locked unchanged.

Source files
------------

// File: rtl/prbs9_checker.sv
// PRBS9 (x^9+x^5+1) receive checker: self-synchronises, then counts bit errors against a local LFSR.
// Status registered on the sampling edge; no backpressure, one bit per enabled clock.
module prbs9_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int WINDOW      = 64,
  parameter int UNLOCK_ERRS = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_bit,
  input  logic             i_enable,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_error,
  output logic [CNT_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_bit_count
);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(UNLOCK_ERRS + 1);

  localparam logic [MW-1:0]    MATCH_TGT = MW'(LOCK_COUNT);
  localparam logic [WW-1:0]    WIN_LAST  = WW'(WINDOW - 1);
  localparam logic [EW-1:0]    ERR_TGT   = EW'(UNLOCK_ERRS);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [0:0]    state;
  logic [8:0]    h;
  logic [3:0]    fill;
  logic [MW-1:0] match_cnt;
  logic [WW-1:0] win_bits;
  logic [EW-1:0] win_errs;

  logic          pred;
  logic          mismatch;
  logic          hit;
  logic [MW-1:0] match_inc;
  logic [EW-1:0] win_errs_inc;

  assign pred         = h[8] ^ h[4];
  assign mismatch     = (i_bit != pred);
  // all-zero history is a fixed point of the recurrence, so it must never count towards lock
  assign hit          = !mismatch && (h != 9'd0);
  assign match_inc    = match_cnt + 1'b1;
  assign win_errs_inc = win_errs + EW'(mismatch);
  assign o_locked     = (state == LOCKED);

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= SEARCH;
      h         <= '0;
      fill      <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      o_error   <= 1'b0;
    end else begin
      o_error <= 1'b0;
      if (i_enable) begin
        if (state == SEARCH) begin
          h <= {h[7:0], i_bit};
          if (fill != 4'd9) begin
            fill <= fill + 4'd1;
          end else if (hit) begin
            if (match_inc == MATCH_TGT) begin
              state     <= LOCKED;
              match_cnt <= '0;
              win_bits  <= '0;
              win_errs  <= '0;
            end else begin
              match_cnt <= match_inc;
            end
          end else begin
            match_cnt <= '0;
          end
        end else begin
          // free-running local LFSR: received bits never enter the history while locked
          h       <= {h[7:0], pred};
          o_error <= mismatch;
          if (win_errs_inc == ERR_TGT) begin
            state     <= SEARCH;
            fill      <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_errs  <= '0;
          end else if (win_bits == WIN_LAST) begin
            win_bits <= '0;
            win_errs <= '0;
          end else begin
            win_bits <= win_bits + 1'b1;
            win_errs <= win_errs_inc;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_err_count <= '0;
      o_bit_count <= '0;
    end else if (i_clear) begin
      o_err_count <= '0;
      o_bit_count <= '0;
    end else if (i_enable && (state == LOCKED)) begin
      if (o_bit_count != CNT_MAX) o_bit_count <= o_bit_count + 1'b1;
      if (mismatch && (o_err_count != CNT_MAX)) o_err_count <= o_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_prbs9_checker.sv
// Bench for prbs9_checker: scoreboard of per-edge lock/error expectations plus a table of strobe scenarios.
module tb_prbs9_checker;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             i_reset;
  logic             i_bit;
  logic             i_enable;
  logic             i_clear;
  logic             o_locked;
  logic             o_error;
  logic [CNT_W-1:0] o_err_count;
  logic [CNT_W-1:0] o_bit_count;

  int checks   = 0;
  int failures = 0;
  logic [8:0] gen;

  typedef struct {
    logic lk;
    logic er;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    string name;
    int    strobes;
    logic  zero_line;
    int    period;
    logic  exp_locked;
    int    exp_errs;
    int    exp_bits;
  } vec_t;

  prbs9_checker #(
    .LOCK_COUNT(16), .WINDOW(64), .UNLOCK_ERRS(8), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_bit(i_bit), .i_enable(i_enable), .i_clear(i_clear),
    .o_locked(o_locked), .o_error(o_error), .o_err_count(o_err_count), .o_bit_count(o_bit_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Reference PRBS9 source; the stream it emits obeys b[n] = b[n-9] ^ b[n-5].
  task automatic gen_next(output logic b);
    b   = gen[8] ^ gen[4];
    gen = {gen[7:0], b};
  endtask

  task automatic step(input logic b, input logic en, input logic clr, input logic lk, input logic er);
    exp_t e;
    i_bit    = b;
    i_enable = en;
    i_clear  = clr;
    e.lk = lk;
    e.er = er;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    check("locked", {31'd0, o_locked}, {31'd0, e.lk});
    check("error",  {31'd0, o_error},  {31'd0, e.er});
    i_clear = 1'b0;
  endtask

  task automatic do_reset();
    i_reset  = 1'b1;
    i_bit    = 1'b0;
    i_enable = 1'b0;
    i_clear  = 1'b0;
    @(posedge clock);
    #1;
    i_reset = 1'b0;
    gen     = 9'h1AA;
  endtask

  // Clean bits numbered 1..n; lock is expected from bit lock_at onward.
  task automatic run_clean(input int n, input int lock_at);
    logic b;
    for (int k = 1; k <= n; k++) begin
      gen_next(b);
      step(b, 1'b1, 1'b0, (k >= lock_at), 1'b0);
    end
  endtask

  task automatic run_error(input logic lk_after);
    logic b;
    gen_next(b);
    step(~b, 1'b1, 1'b0, lk_after, 1'b1);
  endtask

  vec_t vecs[5];

  initial begin
    logic b;
    int   s;
    int   c;
    vecs[0] = '{"zero_line", 200, 1'b1, 1, 1'b0, 0, 0};
    vecs[1] = '{"strobe24",   24, 1'b0, 3, 1'b0, 0, 0};
    vecs[2] = '{"strobe25",   25, 1'b0, 3, 1'b1, 0, 0};
    vecs[3] = '{"strobe40",   40, 1'b0, 3, 1'b1, 0, 15};
    vecs[4] = '{"cont30",     30, 1'b0, 1, 1'b1, 0, 5};

    // Reset state and first lock
    do_reset();
    check("rst_locked", {31'd0, o_locked}, 32'd0);
    check("rst_error",  {31'd0, o_error},  32'd0);
    check("rst_errcnt", 32'(o_err_count), 32'd0);
    check("rst_bitcnt", 32'(o_bit_count), 32'd0);
    run_clean(25, 25);
    run_clean(100, 1);
    check("clean_bitcnt", 32'(o_bit_count), 32'd100);
    check("clean_errcnt", 32'(o_err_count), 32'd0);

    // Single inverted bit: one-cycle pulse, local LFSR undisturbed
    run_error(1'b1);
    run_clean(5, 1);
    check("single_errcnt", 32'(o_err_count), 32'd1);
    check("single_bitcnt", 32'(o_bit_count), 32'd106);
    run_clean(22, 1);
    check("win_bitcnt", 32'(o_bit_count), 32'd128);

    // Eight errors in a fresh window: unlock on the 8th, then relock
    for (int i = 1; i <= 8; i++) run_error(i < 8);
    check("unlock_errcnt", 32'(o_err_count), 32'd9);
    check("unlock_bitcnt", 32'(o_bit_count), 32'd136);
    run_clean(25, 25);
    check("relock_bitcnt", 32'(o_bit_count), 32'd136);

    // Async reset while locked with three errors logged
    do_reset();
    run_clean(25, 25);
    for (int i = 0; i < 3; i++) begin
      run_error(1'b1);
      run_clean(1, 1);
    end
    check("pre_rst_errcnt", 32'(o_err_count), 32'd3);
    #2;
    i_reset = 1'b1;
    #1;
    check("midrst_locked", {31'd0, o_locked}, 32'd0);
    check("midrst_errcnt", 32'(o_err_count), 32'd0);
    check("midrst_bitcnt", 32'(o_bit_count), 32'd0);
    check("midrst_error",  {31'd0, o_error},  32'd0);
    i_reset = 1'b0;
    gen     = 9'h1AA;
    run_clean(25, 25);

    // Clear colliding with an error on the same edge
    run_clean(3, 1);
    gen_next(b);
    step(~b, 1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_errcnt", 32'(o_err_count), 32'd0);
    check("clr_bitcnt", 32'(o_bit_count), 32'd0);
    run_clean(1, 1);
    check("post_clr_bitcnt", 32'(o_bit_count), 32'd1);
    check("post_clr_errcnt", 32'(o_err_count), 32'd0);

    // Table scenarios: stuck-at-0 line and gapped strobes with held data
    for (int v = 0; v < 5; v++) begin
      do_reset();
      s = 0;
      c = 0;
      while (s < vecs[v].strobes) begin
        if ((c % vecs[v].period) == 0) begin
          s++;
          if (vecs[v].zero_line) b = 1'b0;
          else gen_next(b);
          step(b, 1'b1, 1'b0, !vecs[v].zero_line && (s >= 25), 1'b0);
        end else begin
          step(i_bit, 1'b0, 1'b0, !vecs[v].zero_line && (s >= 25), 1'b0);
        end
        c++;
      end
      for (int k = 0; k < 3; k++) step(i_bit, 1'b0, 1'b0, vecs[v].exp_locked, 1'b0);
      check({vecs[v].name, "_locked"}, {31'd0, o_locked}, {31'd0, vecs[v].exp_locked});
      check({vecs[v].name, "_errcnt"}, 32'(o_err_count), 32'(vecs[v].exp_errs));
      check({vecs[v].name, "_bitcnt"}, 32'(o_bit_count), 32'(vecs[v].exp_bits));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL timeout: simulation did not reach the summary in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
